// File: rtl/result_streamer.sv
// Drains a captured frame of systolic-array results as a valid/ready stream,
// shifting and saturating each element to OUT_W bits and counting saturations.
module result_streamer #(
  parameter int ELEM_W = 10,
  parameter int N_ELEM = 16,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic [N_ELEM*ELEM_W-1:0] result_in,
  input  logic [1:0]               shift,
  output logic [OUT_W-1:0]         out_data,
  output logic [3:0]               out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               sat_cnt,
  output logic [1:0]               state_dbg
);

  // Handshake: an element transfers on a rising edge where out_valid && out_ready.
  // While out_valid=1 and out_ready=0 the element fields hold; out_valid never
  // depends combinationally on out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0]        LAST_IDX = 4'(N_ELEM - 1);
  localparam logic [ELEM_W-1:0] MAX_OUT  = ELEM_W'((1 << OUT_W) - 1);

  state_t            state;
  logic [ELEM_W-1:0] buf_q [N_ELEM];
  logic [1:0]        shift_q;
  logic              cur_sat;
  logic [3:0]        next_idx;
  logic [OUT_W:0]    first_sh;
  logic [OUT_W:0]    next_sh;

  // Returns {saturated, output word} for one element.
  function automatic logic [OUT_W:0] shape(input logic [ELEM_W-1:0] e,
                                           input logic [1:0] sh);
    logic [ELEM_W-1:0] s;
    s = e >> sh;
    if (s > MAX_OUT) return {1'b1, {OUT_W{1'b1}}};
    else             return {1'b0, s[OUT_W-1:0]};
  endfunction

  always_comb begin
    next_idx = out_idx + 4'd1;
    first_sh = shape(result_in[ELEM_W-1:0], shift);
    next_sh  = shape(buf_q[next_idx], shift_q);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      for (int k = 0; k < N_ELEM; k++) buf_q[k] <= '0;
      shift_q   <= '0;
      cur_sat   <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < N_ELEM; k++)
              buf_q[k] <= result_in[k*ELEM_W +: ELEM_W];
            shift_q   <= shift;
            sat_cnt   <= '0;
            out_idx   <= '0;
            out_data  <= first_sh[OUT_W-1:0];
            cur_sat   <= first_sh[OUT_W];
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == 4'd0);
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (cur_sat) sat_cnt <= sat_cnt + 5'd1;
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              // Next element is staged on the same edge so there is no bubble.
              out_idx  <= next_idx;
              out_data <= next_sh[OUT_W-1:0];
              cur_sat  <= next_sh[OUT_W];
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: frame table with hand-computed outputs,
// plus backpressure, mid-frame restart, mid-frame reset and held-start sequences.
module tb_result_streamer;
  localparam int ELEM_W = 10;
  localparam int N_ELEM = 16;
  localparam int OUT_W  = 8;

  logic                     clk = 1'b0;
  logic                     res = 1'b1;
  logic                     start = 1'b0;
  logic                     out_ready = 1'b0;
  logic [N_ELEM*ELEM_W-1:0] result_in = '0;
  logic [1:0]               shift = 2'd0;
  logic [OUT_W-1:0]         out_data;
  logic [3:0]               out_idx;
  logic                     out_valid, out_last, busy, done;
  logic [4:0]               sat_cnt;
  logic [1:0]               state_dbg;

  result_streamer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .OUT_W(OUT_W)) dut (
    .clk(clk), .res(res), .start(start), .result_in(result_in), .shift(shift),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .sat_cnt(sat_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][9:0] elem;
    logic [1:0]       sh;
    logic [15:0][7:0] exp;
    logic [4:0]       exp_sat;
  } frame_t;

  frame_t      frames [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [12:0] exp_q[$];   // {idx, data, last}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int f);
    result_in = frames[f].elem;
    shift     = frames[f].sh;
    exp_q.delete();
    for (int k = 0; k < N_ELEM; k++)
      exp_q.push_back({4'(k), frames[f].exp[k], (k == N_ELEM - 1)});
  endtask

  // Called at the negedge where element 0 is visible; returns at the negedge
  // where the DONE state is visible. mode 0: ready always, mode 1: 1,0,0 pattern.
  task automatic stream_check(input int f, input int mode, input bit restart);
    int          got = 0;
    int          cyc = 0;
    bit          held = 0;
    bit          pulsed = 0;
    logic [7:0]  hd;
    logic [3:0]  hi;
    logic [12:0] e;
    while (got < N_ELEM && cyc < 300) begin
      cyc++;
      start = 1'b0;
      if (held) begin
        check("hold_data", out_data, hd);
        check("hold_idx", out_idx, hi);
      end
      check("stream_valid", out_valid, 1);
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 1);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        got++;
        check("data", out_data, e[8:1]);
        check("idx", out_idx, e[12:9]);
        check("last", out_last, e[0]);
        held = 0;
      end else begin
        held = out_valid;
        hd   = out_data;
        hi   = out_idx;
      end
      if (restart && !pulsed && got == 5) begin
        start     = 1'b1;
        result_in = ~result_in;
        shift     = ~shift;
        pulsed    = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (got < N_ELEM) check("stream_timeout", got, N_ELEM);
    check("done_valid", out_valid, 0);
    check("done_last", out_last, 0);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_state", state_dbg, 2);
    check("done_sat_cnt", sat_cnt, frames[f].exp_sat);
  endtask

  task automatic run_frame(input int f, input int mode, input bit restart);
    load(f);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_valid", out_valid, 1);
    check("first_idx", out_idx, 0);
    check("first_busy", busy, 1);
    check("first_sat_cnt", sat_cnt, 0);
    stream_check(f, mode, restart);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_sat_hold", sat_cnt, frames[f].exp_sat);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sat_cnt"}, sat_cnt, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    // Frame table: inputs and hand-computed outputs.
    for (int k = 0; k < N_ELEM; k++) begin
      frames[0].elem[k] = 10'(k * 60);
      frames[1].elem[k] = 10'(k * 60);
      frames[3].elem[k] = 10'(1023 - 64 * k);
    end
    frames[0].sh      = 2'd0;
    frames[0].exp     = {{11{8'd255}}, 8'd240, 8'd180, 8'd120, 8'd60, 8'd0};
    frames[0].exp_sat = 5'd11;
    frames[1].sh      = 2'd2;
    frames[1].exp     = {8'd225, 8'd210, 8'd195, 8'd180, 8'd165, 8'd150, 8'd135, 8'd120,
                         8'd105, 8'd90, 8'd75, 8'd60, 8'd45, 8'd30, 8'd15, 8'd0};
    frames[1].exp_sat = 5'd0;
    frames[2].elem    = {10'd1022, 10'd2, 10'd200, 10'd100, 10'd768, 10'd767, 10'd300, 10'd3,
                         10'd0, 10'd1, 10'd1023, 10'd512, 10'd511, 10'd510, 10'd256, 10'd255};
    frames[2].sh      = 2'd1;
    frames[2].exp     = {8'd255, 8'd1, 8'd100, 8'd50, 8'd255, 8'd255, 8'd150, 8'd1,
                         8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd127};
    frames[2].exp_sat = 5'd5;
    frames[3].sh      = 2'd3;
    frames[3].exp     = {8'd7, 8'd15, 8'd23, 8'd31, 8'd39, 8'd47, 8'd55, 8'd63,
                         8'd71, 8'd79, 8'd87, 8'd95, 8'd103, 8'd111, 8'd119, 8'd127};
    frames[3].exp_sat = 5'd0;

    #2;
    check_zero("reset");
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    run_frame(0, 0, 0);   // saturating frame, full rate
    run_frame(1, 1, 1);   // shift 2, backpressure, ignored restart
    run_frame(2, 0, 0);   // saturation boundaries around 255/256
    run_frame(3, 1, 0);   // shift 3 with backpressure

    // Reset asserted while element 7 is on the bus.
    load(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_reset_idx", out_idx, 7);
    check("pre_reset_data", out_data, frames[2].exp[7]);
    #2 res = 1'b1;
    #1 check_zero("midreset");
    out_ready = 1'b0;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("post_reset_valid", out_valid, 0);
    run_frame(3, 0, 0);

    // start held high: back-to-back frames, sat_cnt cleared at each start.
    load(0);
    start = 1'b1;
    @(negedge clk);
    check("held1_valid", out_valid, 1);
    check("held1_idx", out_idx, 0);
    stream_check(0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    check("held_gap_valid", out_valid, 0);
    check("held_gap_busy", busy, 0);
    check("held_gap_sat", sat_cnt, 11);
    load(3);
    @(negedge clk);
    check("held2_valid", out_valid, 1);
    check("held2_idx", out_idx, 0);
    check("held2_sat_clr", sat_cnt, 0);
    stream_check(3, 0, 0);
    start = 1'b0;
    @(negedge clk);
    check("held_end_busy", busy, 0);
    @(negedge clk);
    check("held_end_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
